// File: rtl/quad_enc_decoder.sv
// Quadrature encoder decoder: synchronises A/B/I, tracks the Gray-code phase,
// and maintains a signed position count, step period, direction and sticky flags.
module quad_enc_decoder #(
    parameter int COUNT_WIDTH = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          quad_A,
    input  logic                          quad_B,
    input  logic                          quad_I,
    input  logic                          enable,
    input  logic                          clear_count,
    input  logic                          index_clear_en,
    output logic signed [COUNT_WIDTH-1:0] count,
    output logic                          direction,
    output logic        [COUNT_WIDTH-1:0] period,
    output logic                          period_valid,
    output logic                          error,
    output logic                          index_seen
);

    typedef enum logic [2:0] {
        S_INIT,
        S_00,
        S_10,
        S_11,
        S_01
    } state_t;

    localparam int INIT_W = $clog2(SYNC_STAGES + 1) + 1;
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(SYNC_STAGES);

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (&v) ? v : v + COUNT_WIDTH'(1);
    endfunction

    function automatic state_t state_of_ab(input logic [1:0] ab);
        case (ab)
            2'b00:   return S_00;
            2'b10:   return S_10;
            2'b11:   return S_11;
            default: return S_01;
        endcase
    endfunction

    function automatic logic [1:0] ab_of_state(input state_t s);
        case (s)
            S_10:    return 2'b10;
            S_11:    return 2'b11;
            S_01:    return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    logic [SYNC_STAGES-1:0]        r_sync_a;
    logic [SYNC_STAGES-1:0]        r_sync_b;
    logic [SYNC_STAGES-1:0]        r_sync_i;
    logic                          r_i_prev;
    logic [INIT_W-1:0]             r_init_cnt;
    state_t                        r_state;
    state_t                        w_state_nxt;
    logic                          w_fwd;
    logic                          w_rev;
    logic                          w_dbl;
    logic [1:0]                    w_ab;
    logic                          w_i;
    logic                          w_i_rise;
    logic signed [COUNT_WIDTH-1:0] r_count;
    logic                          r_direction;
    logic [COUNT_WIDTH-1:0]        r_period;
    logic [COUNT_WIDTH-1:0]        r_timer;
    logic                          r_period_valid;
    logic                          r_error;
    logic                          r_index_seen;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync_a <= '0;
            r_sync_b <= '0;
            r_sync_i <= '0;
            r_i_prev <= 1'b0;
        end else begin
            r_sync_a <= {r_sync_a[SYNC_STAGES-2:0], quad_A};
            r_sync_b <= {r_sync_b[SYNC_STAGES-2:0], quad_B};
            r_sync_i <= {r_sync_i[SYNC_STAGES-2:0], quad_I};
            r_i_prev <= w_i;
        end
    end

    assign w_ab     = {r_sync_a[SYNC_STAGES-1], r_sync_b[SYNC_STAGES-1]};
    assign w_i      = r_sync_i[SYNC_STAGES-1];
    assign w_i_rise = w_i & ~r_i_prev;

    // S_INIT waits until the synchroniser chain holds real pin values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_init_cnt <= '0;
            r_state    <= S_INIT;
        end else begin
            if (r_state == S_INIT && r_init_cnt != INIT_LAST) begin
                r_init_cnt <= r_init_cnt + INIT_W'(1);
            end
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fwd       = 1'b0;
        w_rev       = 1'b0;
        w_dbl       = 1'b0;
        if (r_state == S_INIT) begin
            if (r_init_cnt == INIT_LAST) begin
                w_state_nxt = state_of_ab(w_ab);
            end
        end else begin
            w_state_nxt = state_of_ab(w_ab);
            case ({ab_of_state(r_state), w_ab})
                4'b0010, 4'b1011, 4'b1101, 4'b0100: w_fwd = 1'b1;
                4'b0001, 4'b0111, 4'b1110, 4'b1000: w_rev = 1'b1;
                4'b0011, 4'b1100, 4'b0110, 4'b1001: w_dbl = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count        <= '0;
            r_direction    <= 1'b0;
            r_period       <= '0;
            r_timer        <= '0;
            r_period_valid <= 1'b0;
            r_error        <= 1'b0;
            r_index_seen   <= 1'b0;
        end else begin
            r_period_valid <= 1'b0;
            if (enable && (w_fwd || w_rev)) begin
                r_direction <= w_fwd;
            end
            // clear_count beats every other update, but leaves direction alone.
            if (clear_count) begin
                r_count      <= '0;
                r_period     <= '0;
                r_timer      <= '0;
                r_error      <= 1'b0;
                r_index_seen <= 1'b0;
            end else begin
                if (w_i_rise) begin
                    r_index_seen <= 1'b1;
                end
                if (enable) begin
                    r_timer <= sat_inc(r_timer);
                    if (w_fwd || w_rev) begin
                        r_period       <= sat_inc(r_timer);
                        r_period_valid <= 1'b1;
                        r_timer        <= '0;
                    end
                    if (w_dbl) begin
                        r_error <= 1'b1;
                    end
                    if (w_i_rise && index_clear_en) begin
                        r_count <= '0;
                    end else if (w_fwd) begin
                        r_count <= r_count + COUNT_WIDTH'(1);
                    end else if (w_rev) begin
                        r_count <= r_count - COUNT_WIDTH'(1);
                    end
                end
            end
        end
    end

    assign count        = r_count;
    assign direction    = r_direction;
    assign period       = r_period;
    assign period_valid = r_period_valid;
    assign error        = r_error;
    assign index_seen   = r_index_seen;

endmodule

// File: tb/tb_quad_enc_decoder.sv
// Directed bench for quad_enc_decoder at an 8-bit count width so wrap and
// saturation boundaries are reachable in a short run.
module tb_quad_enc_decoder;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          quad_A;
    logic          quad_B;
    logic          quad_I;
    logic          enable;
    logic          clear_count;
    logic          index_clear_en;
    logic [CW-1:0] count;
    logic          direction;
    logic [CW-1:0] period;
    logic          period_valid;
    logic          error;
    logic          index_seen;

    int n_tests = 0;
    int n_fail  = 0;
    int ph      = 0;
    logic [1:0] ab_of_ph [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    quad_enc_decoder #(.COUNT_WIDTH(CW), .SYNC_STAGES(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .quad_A         (quad_A),
        .quad_B         (quad_B),
        .quad_I         (quad_I),
        .enable         (enable),
        .clear_count    (clear_count),
        .index_clear_en (index_clear_en),
        .count          (count),
        .direction      (direction),
        .period         (period),
        .period_valid   (period_valid),
        .error          (error),
        .index_seen     (index_seen)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // delta: +1 forward, -1 reverse, 2 double-bit jump
    task automatic step(input int delta, input int gap);
        ph = (ph + delta + 4) % 4;
        {quad_A, quad_B} = ab_of_ph[ph];
        tick(gap);
    endtask

    task automatic pulse_clear();
        clear_count = 1'b1;
        tick(1);
        clear_count = 1'b0;
    endtask

    initial begin
        reset = 1'b0; quad_A = 1'b0; quad_B = 1'b0; quad_I = 1'b0;
        enable = 1'b1; clear_count = 1'b0; index_clear_en = 1'b0;
        tick(2);
        check("rst_count", count, 0);
        check("rst_dir", direction, 0);
        check("rst_period", period, 0);
        check("rst_pv", period_valid, 0);
        check("rst_error", error, 0);
        check("rst_index", index_seen, 0);
        reset = 1'b1;
        tick(10);

        // Latency: pin edge to count update is three clock edges
        step(1, 2);
        check("lat_edge2", count, 0);
        tick(1);
        check("lat_edge3", count, 1);
        tick(10);

        // Reset again with AB=10 held, then 8 full forward cycles at 10 clk/edge
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(10);
        for (int i = 0; i < 32; i++) begin
            if (i == 2) begin
                step(1, 3);
                check("pv_pulse", period_valid, 1);
                tick(1);
                check("pv_drop", period_valid, 0);
                tick(6);
            end else begin
                step(1, 10);
            end
            if (i == 1) check("period_10", period, 10);
        end
        check("fwd32_count", count, 32);
        check("fwd32_dir", direction, 1);
        check("fwd32_error", error, 0);

        // Wrap boundaries
        pulse_clear();
        check("clr_count", count, 0);
        check("clr_period", period, 0);
        step(-1, 5);
        check("rev_wrap_count", count, 8'hFF);
        check("rev_wrap_dir", direction, 0);
        step(1, 5);
        check("back_to_zero", count, 0);
        for (int i = 0; i < 127; i++) step(1, 4);
        check("max_pos", count, 8'h7F);
        step(1, 5);
        check("fwd_wrap_count", count, 8'h80);
        check("fwd_wrap_dir", direction, 1);

        // Period saturates at all-ones after a long idle
        tick(300);
        step(1, 5);
        check("period_sat", period, 8'hFF);
        check("sat_count", count, 8'h81);

        // Double-bit jump sets error without counting
        step(2, 5);
        check("dbl_error", error, 1);
        check("dbl_count", count, 8'h81);
        check("dbl_dir", direction, 1);
        pulse_clear();
        check("clr_error", error, 0);
        check("clr_count2", count, 0);

        // Index rising edge coincident with a step at count 57
        for (int i = 0; i < 57; i++) step(1, 4);
        check("count_57", count, 57);
        index_clear_en = 1'b1;
        quad_I = 1'b1;
        step(1, 5);
        check("idx_count", count, 0);
        check("idx_seen", index_seen, 1);
        quad_I = 1'b0;
        index_clear_en = 1'b0;
        step(1, 5);
        check("idx_after_count", count, 1);
        check("idx_period", period, 5);
        check("idx_sticky", index_seen, 1);

        // enable=0 holds count, period and period_valid
        enable = 1'b0;
        step(1, 3);
        check("dis_pv", period_valid, 0);
        tick(2);
        for (int i = 0; i < 3; i++) step(1, 5);
        check("dis_count", count, 1);
        check("dis_period", period, 5);
        enable = 1'b1;
        step(1, 5);
        check("en_count", count, 2);
        check("en_error", error, 0);

        // Asynchronous reset mid-motion, released with AB=11 held
        reset = 1'b0;
        #2;
        check("async_rst_count", count, 0);
        ph = 2;
        {quad_A, quad_B} = ab_of_ph[ph];
        tick(3);
        reset = 1'b1;
        tick(3);
        check("resync_count", count, 0);
        check("resync_error", error, 0);
        step(1, 5);
        check("resync_step_count", count, 1);
        check("resync_step_dir", direction, 1);
        check("resync_step_error", error, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
